// File: rtl/exec_step_controller_pkg.sv
// Shared definitions for the execution step controller.
//   exec_state_t      : controller state, 2-bit encoding driven straight onto the LEDs
//                       (00 HALT, 01 RUN, 10 BRK, 11 DONE)
//   HALT_INST_DEFAULT : instruction word that ends a RUN session (beq x0,x0,0)
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_BRK  = 2'b10,
        ST_DONE = 2'b11
    } exec_state_t;

    localparam logic [31:0] HALT_INST_DEFAULT = 32'h0000_0063;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered falling-edge detector, used
// for active-low push buttons that are asynchronous to clk.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (flops reset to the released level 1)
//   din        : raw asynchronous input (active-low button)
//   fall_pulse : one-cycle pulse, high in the 3rd cycle after din falls
// No debounce: every bounce that survives synchronization produces a pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall_pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic pulse_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            // Registered so the pulse is glitch-free and has a fixed latency.
            pulse_reg <= prev_reg & ~sync2_reg;
        end
    end

    assign fall_pulse = pulse_reg;

endmodule

// File: rtl/exec_step_controller.sv
// Execution step controller for the single-cycle RV datapath. Generates a
// one-cycle clock enable (cpu_en) instead of a slow divided clock.
//   clock_reg   : system clock (CLOCK_50)
//   reset       : asynchronous active-low reset (KEY[2])
//   run_sw      : 1 = continuous run requested
//   step_key_n  : raw active-low step button, asynchronous
//   brk_en      : breakpoint enable
//   brk_addr    : breakpoint PC
//   pc, inst    : current PC / instruction from the datapath
//   cpu_en      : registered one-cycle advance enable
//   state       : 00 HALT, 01 RUN, 10 BRK, 11 DONE
//   instr_count : saturating count of cpu_en pulses
module exec_step_controller
    import exec_ctrl_pkg::*;
#(
    parameter int          TICK_DIV  = 25000000,
    parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT,
    parameter int          CNT_W     = 16
) (
    input  logic             clock_reg,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_key_n,
    input  logic             brk_en,
    input  logic [7:0]       brk_addr,
    input  logic [7:0]       pc,
    input  logic [31:0]      inst,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    exec_state_t      state_reg;
    logic             cpu_en_reg;
    logic [CNT_W-1:0] instr_count_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             skip_brk_reg;

    logic step_edge;
    logic decision;
    logic halt_hit;
    logic brk_hit;
    logic fire;

    sync_edge_det u_step_sync (
        .clk        (clock_reg),
        .rst_n      (reset),
        .din        (step_key_n),
        .fall_pulse (step_edge)
    );

    // pc/inst are only looked at in the decision cycle; a dropped run_sw
    // suppresses the decision so leaving RUN never issues a pulse.
    always_comb begin
        decision = (state_reg == ST_RUN) && run_sw && (div_cnt_reg == DIV_LAST);
        halt_hit = (inst == HALT_INST);
        brk_hit  = brk_en && (pc == brk_addr) && !skip_brk_reg;
        fire     = ((state_reg == ST_HALT) && !run_sw && step_edge) ||
                   (decision && !halt_hit && !brk_hit);
    end

    always_ff @(posedge clock_reg or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_HALT;
            cpu_en_reg      <= 1'b0;
            instr_count_reg <= '0;
            div_cnt_reg     <= '0;
            skip_brk_reg    <= 1'b0;
        end else begin
            cpu_en_reg <= fire;
            if (fire && (instr_count_reg != '1)) begin
                instr_count_reg <= instr_count_reg + 1'b1;
            end

            case (state_reg)
                ST_HALT: begin
                    div_cnt_reg  <= '0;
                    skip_brk_reg <= 1'b0;
                    // run_sw wins over a coincident step; the step is dropped.
                    if (run_sw) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run_sw) begin
                        state_reg    <= ST_HALT;
                        div_cnt_reg  <= '0;
                        skip_brk_reg <= 1'b0;
                    end else if (decision) begin
                        div_cnt_reg  <= '0;
                        // Cleared on the pulse it allowed, or on leaving RUN.
                        skip_brk_reg <= 1'b0;
                        if (halt_hit) begin
                            state_reg <= ST_DONE;
                        end else if (brk_hit) begin
                            state_reg <= ST_BRK;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                ST_BRK: begin
                    div_cnt_reg <= '0;
                    if (!run_sw) begin
                        state_reg    <= ST_HALT;
                        skip_brk_reg <= 1'b0;
                    end else if (step_edge) begin
                        // Resume past the breakpointed PC without re-trapping.
                        state_reg    <= ST_RUN;
                        skip_brk_reg <= 1'b1;
                    end
                end
                default: begin
                    // DONE is sticky until reset.
                    div_cnt_reg  <= '0;
                    skip_brk_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_en      = cpu_en_reg;
    assign state       = state_reg;
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_exec_step_controller.sv
module tb_exec_step_controller;
    import exec_ctrl_pkg::*;

    localparam int          TD   = 4;
    localparam logic [31:0] HALT = 32'h0000_0063;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        run_sw     = 1'b0;
    logic        step_key_n = 1'b1;
    logic        brk_en     = 1'b0;
    logic [7:0]  brk_addr   = 8'h00;
    logic [7:0]  pc         = 8'h00;
    logic [31:0] inst       = NOP;

    logic        cpu_en, cpu_en2;
    logic [1:0]  state, state2;
    logic [15:0] instr_count;
    logic [2:0]  instr_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_step_controller #(.TICK_DIV(TD), .HALT_INST(HALT), .CNT_W(16)) dut (
        .clock_reg(clk), .reset(reset), .run_sw(run_sw), .step_key_n(step_key_n),
        .brk_en(brk_en), .brk_addr(brk_addr), .pc(pc), .inst(inst),
        .cpu_en(cpu_en), .state(state), .instr_count(instr_count)
    );

    // Narrow-counter copy used to observe saturation without 65k pulses.
    exec_step_controller #(.TICK_DIV(TD), .HALT_INST(HALT), .CNT_W(3)) dut_sat (
        .clock_reg(clk), .reset(reset), .run_sw(run_sw), .step_key_n(step_key_n),
        .brk_en(brk_en), .brk_addr(brk_addr), .pc(pc), .inst(inst),
        .cpu_en(cpu_en2), .state(state2), .instr_count(instr_count2)
    );

    // Behavioural reference: states as integers, RUN timing as "cycles spent
    // in RUN modulo TD", step press seen from a history of sampled key levels.
    int       m_state;     // 0 HALT, 1 RUN, 2 BRK, 3 DONE
    int       m_run_cyc;
    int       m_cnt;
    bit       m_skip;
    bit       m_en;
    bit [3:0] kh;          // kh[i] = key level sampled i+1 edges ago

    always @(posedge clk or negedge reset) begin
        bit se;
        bit fire;
        if (!reset) begin
            m_state = 0; m_run_cyc = 0; m_cnt = 0; m_skip = 0; m_en = 0; kh = 4'hF;
        end else begin
            se   = kh[3] & ~kh[2];
            fire = 0;
            case (m_state)
                0: if (run_sw) begin m_state = 1; m_run_cyc = 0; end
                   else if (se) fire = 1;
                1: begin
                    if (!run_sw) begin
                        m_state = 0; m_skip = 0;
                    end else begin
                        if ((m_run_cyc % TD) == TD - 1) begin
                            if (inst == HALT) begin m_state = 3; m_skip = 0; end
                            else if (brk_en && pc == brk_addr && !m_skip) m_state = 2;
                            else begin fire = 1; m_skip = 0; end
                        end
                        m_run_cyc++;
                    end
                end
                2: if (!run_sw) m_state = 0;
                   else if (se) begin m_state = 1; m_run_cyc = 0; m_skip = 1; end
                default: ;
            endcase
            m_en = fire;
            if (fire && m_cnt < 65535) m_cnt++;
            kh = {kh[2:0], step_key_n};
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; run_sw = 1'b0; step_key_n = 1'b1; brk_en = 1'b0;
        brk_addr = 8'h00; pc = 8'h00; inst = NOP;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        checks++; if (instr_count2 !== 3'd0) begin errors++; $display("FAIL reset_count_sat got=%0d exp=0", instr_count2); end
        $display("reset: cpu_en=%b state=%b count=%0d", cpu_en, state, instr_count);
        reset = 1'b1;
    endtask

    task automatic test_step();
        do_reset();
        step_key_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_en !== 1'(k == 4)) begin
                errors++; $display("FAIL step_pulse k=%0d got=%b exp=%b", k, cpu_en, (k == 4));
            end
            if (k == 5) step_key_n = 1'b1;
        end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL step_state got=%b exp=00", state); end
        checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL step_count got=%0d exp=1", instr_count); end
        $display("step: state=%b count=%0d", state, instr_count);
    endtask

    task automatic test_run();
        int last = -1;
        int n = 0;
        do_reset();
        run_sw = 1'b1;
        for (int cyc = 1; cyc <= 120 && n < 10; cyc++) begin
            @(negedge clk);
            if (cpu_en) begin
                n++;
                if (last < 0) begin
                    checks++; if (cyc != TD + 1) begin errors++; $display("FAIL run_first got=%0d exp=%0d", cyc, TD + 1); end
                end else begin
                    checks++; if (cyc - last != TD) begin errors++; $display("FAIL run_spacing got=%0d exp=%0d", cyc - last, TD); end
                end
                checks++;
                if (instr_count2 !== 3'((n > 7) ? 7 : n)) begin
                    errors++; $display("FAIL run_sat_count got=%0d exp=%0d", instr_count2, (n > 7) ? 7 : n);
                end
                $display("run: pulse %0d at cycle %0d pc=%02h count=%0d", n, cyc, pc, instr_count);
                last = cyc;
                pc = pc + 8'd4;
            end
        end
        checks++; if (n != 10) begin errors++; $display("FAIL run_pulses got=%0d exp=10", n); end
        checks++; if (instr_count !== 16'd10) begin errors++; $display("FAIL run_count got=%0d exp=10", instr_count); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state got=%b exp=01", state); end
    endtask

    task automatic test_brk();
        int n = 0;
        bit hit = 0;
        bit resumed = 0;
        do_reset();
        brk_en = 1'b1; brk_addr = 8'h0C; run_sw = 1'b1;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clk);
            if (cpu_en) begin n++; pc = pc + 8'd4; end
            if (state == 2'b10) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL brk_reach got=%b exp=10", state); end
        checks++; if (n != 3) begin errors++; $display("FAIL brk_pulses got=%0d exp=3", n); end
        checks++; if (pc !== 8'h0C) begin errors++; $display("FAIL brk_pc got=%02h exp=0c", pc); end
        n = 0;
        repeat (10) begin @(negedge clk); if (cpu_en) n++; end
        checks++; if (n != 0 || state !== 2'b10) begin errors++; $display("FAIL brk_hold pulses=%0d state=%b exp 0/10", n, state); end
        $display("brk: stopped at pc=%02h state=%b", pc, state);
        step_key_n = 1'b0;
        for (int k = 1; k <= 30 && !resumed; k++) begin
            @(negedge clk);
            if (k == 5) step_key_n = 1'b1;
            if (cpu_en) begin
                resumed = 1;
                checks++; if (state !== 2'b01) begin errors++; $display("FAIL brk_resume_state got=%b exp=01", state); end
                pc = pc + 8'd4;
            end
        end
        step_key_n = 1'b1;
        checks++; if (!resumed || pc !== 8'h10) begin errors++; $display("FAIL brk_resume pc=%02h exp=10", pc); end
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cpu_en) begin n++; pc = pc + 8'd4; end
        end
        checks++; if (state !== 2'b01 || n == 0) begin errors++; $display("FAIL brk_no_retrap state=%b pulses=%0d", state, n); end
        $display("brk: resumed, pc=%02h state=%b", pc, state);
    endtask

    task automatic test_done();
        int n = 0;
        int bad = 0;
        bit done = 0;
        do_reset();
        run_sw = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 2; cyc++) begin
            @(negedge clk);
            if (cpu_en) begin n++; pc = pc + 8'd4; end
        end
        inst = HALT;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (cpu_en) bad++;
            if (state == 2'b11) done = 1;
        end
        checks++; if (!done || bad != 0) begin errors++; $display("FAIL done_enter state=%b pulses=%0d exp 11/0", state, bad); end
        run_sw = 1'b0;
        repeat (3) begin @(negedge clk); if (cpu_en) bad++; end
        run_sw = 1'b1;
        step_key_n = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 5) step_key_n = 1'b1;
            if (cpu_en) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL done_sticky_pulse got=%0d exp=0", bad); end
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL done_sticky_state got=%b exp=11", state); end
        checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL done_count got=%0d exp=2", instr_count); end
        $display("done: state=%b count=%0d", state, instr_count);
        do_reset();
        checks++; if (state !== 2'b00 || instr_count !== 16'd0) begin errors++; $display("FAIL done_reset state=%b count=%0d exp 00/0", state, instr_count); end
    endtask

    task automatic test_run_step_same();
        do_reset();
        step_key_n = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_en !== 1'(k == 8)) begin
                errors++; $display("FAIL same_cycle k=%0d got=%b exp=%b", k, cpu_en, (k == 8));
            end
            if (k == 3) run_sw = 1'b1;
            if (k == 5) step_key_n = 1'b1;
        end
        checks++; if (state !== 2'b01 || instr_count !== 16'd1) begin errors++; $display("FAIL same_cycle_end state=%b count=%0d exp 01/1", state, instr_count); end
        $display("same_cycle: state=%b count=%0d", state, instr_count);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        do_reset();
        run_sw = 1'b1;
        for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
            @(negedge clk);
            if (cpu_en) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_reset_nopulse got=0 exp=1"); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (cpu_en !== 1'b0 || state !== 2'b00 || instr_count !== 16'd0 || instr_count2 !== 3'd0) begin
            errors++; $display("FAIL mid_reset got en=%b st=%b cnt=%0d exp 0/00/0", cpu_en, state, instr_count);
        end
        $display("mid_reset: cpu_en=%b state=%b count=%0d", cpu_en, state, instr_count);
        @(negedge clk);
        reset = 1'b1; run_sw = 1'b0;
    endtask

    task automatic test_random();
        bit prev_en = 0;
        do_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            checks++;
            if (cpu_en !== m_en || state !== 2'(m_state) || instr_count !== 16'(m_cnt) ||
                instr_count2 !== 3'((m_cnt > 7) ? 7 : m_cnt)) begin
                errors++;
                $display("FAIL random cyc=%0d got en=%b st=%b cnt=%0d/%0d exp en=%b st=%0d cnt=%0d",
                         cyc, cpu_en, state, instr_count, instr_count2, m_en, m_state, m_cnt);
            end
            checks++;
            if (prev_en && cpu_en) begin errors++; $display("FAIL random_back_to_back cyc=%0d got=11 exp=no consecutive", cyc); end
            prev_en = cpu_en;
            if (cpu_en) begin
                $display("random: pulse cyc=%0d pc=%02h state=%b count=%0d", cyc, pc, state, instr_count);
                pc = (pc + 8'd4) & 8'h1F;
            end
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 149) == 0) reset = 1'b0;
            if ($urandom_range(0, 29) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 7) == 0) step_key_n = ~step_key_n;
            if ($urandom_range(0, 49) == 0) brk_en = ~brk_en;
            if ($urandom_range(0, 19) == 0) brk_addr = 8'($urandom_range(0, 7) * 4);
            inst = ($urandom_range(0, 59) == 0) ? HALT : NOP;
        end
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_step();
        test_run();
        test_brk();
        test_done();
        test_run_step_same();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
